// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - state register, round counter and handshakes for an iterative AES datapath
// Optional abort input is enabled by defining AES_SEQ_ABORT_EN.
module aes_round_sequencer #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         keys_valid,
`ifdef AES_SEQ_ABORT_EN
   input  logic         abort,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_block,
   output logic [127:0] dp_state,
   output logic [3:0]   dp_round,
   output logic [1:0]   dp_mode,
   input  logic [127:0] dp_result,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_block,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   localparam logic [1:0] MODE_INIT  = 2'd0;
   localparam logic [1:0] MODE_FULL  = 2'd1;
   localparam logic [1:0] MODE_FINAL = 2'd2;

   // Nr == Nk+6 in every legal build; the min keeps the last round inside the key store.
   localparam logic [3:0] RND_LAST = 4'((Nr < Nk + 6) ? Nr : Nk + 6);

   state_e       fsm_q, fsm_d;
   logic [127:0] st_q, st_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         live_q;
   logic         abort_w;

`ifdef AES_SEQ_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // live_q holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q  <= S_IDLE;
         st_q   <= '0;
         rnd_q  <= '0;
         live_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         rnd_q  <= rnd_d;
         live_q <= 1'b1;
      end
   end

   always_comb begin
      fsm_d     = fsm_q;
      st_d      = st_q;
      rnd_d     = rnd_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_block = '0;
      busy      = 1'b0;
      dp_state  = st_q;
      dp_round  = '0;
      dp_mode   = MODE_INIT;

      unique case (fsm_q)
         S_IDLE: begin
            in_ready = live_q && keys_valid;
            if (in_valid && in_ready) begin
               st_d  = in_block;
               rnd_d = '0;
               fsm_d = S_RUN;
            end
         end

         S_RUN: begin
            busy     = 1'b1;
            dp_round = rnd_q;
            if (rnd_q == 4'd0)
               dp_mode = MODE_INIT;
            else if (rnd_q == RND_LAST)
               dp_mode = MODE_FINAL;
            else
               dp_mode = MODE_FULL;

            if (abort_w) begin
               st_d  = '0;
               rnd_d = '0;
               fsm_d = S_IDLE;
            end else if (keys_valid) begin
               st_d = dp_result;
               if (rnd_q == RND_LAST) begin
                  rnd_d = '0;
                  fsm_d = S_DONE;
               end else begin
                  rnd_d = rnd_q + 4'd1;
               end
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            out_block = st_q;
            if (abort_w) begin
               st_d  = '0;
               rnd_d = '0;
               fsm_d = S_IDLE;
            end else if (out_ready) begin
               // Back-to-back: take the next block on the same edge the result leaves.
               if (in_valid && keys_valid) begin
                  in_ready = 1'b1;
                  st_d     = in_block;
                  rnd_d    = '0;
                  fsm_d    = S_RUN;
               end else begin
                  fsm_d = S_IDLE;
               end
            end
         end

         default: begin
            fsm_d = S_IDLE;
         end
      endcase
   end

endmodule
